bus_sync_tx_arbiter: RTL and testbench
======================================

// Module: bus_sync_tx_arbiter
// PURPOSE
//  Source-domain controller that shares one DATA_SYNC bus crossing among NUM_REQ requesters.
//  Round-robin arbitration picks one word, drives unsync_bus/bus_enable with a four-phase
//  handshake, and waits for the destination's acknowledge before starting the next word.
//  The acknowledge arrives through a 1-bit synchronizer outside this block.
//  Guarantees unsync_bus is stable for the whole time bus_enable is high and through release.
// PARAMETERS
//  NUM_REQ      4   number of requesters (>=2)
//  BUS_WIDTH    8   data word width, matches DATA_SYNC BUS_WIDTH
//  HOLD_CYCLES  3   minimum cycles bus_enable stays high (>=1), independent of ack
//  ACK_TIMEOUT  16  max cycles in SEND waiting for ack_sync before abort (>HOLD_CYCLES)
// PORTS
//  CLK          in   1                  source-domain clock, rising edge
//  RST          in   1                  synchronous reset, active low
//  req          in   NUM_REQ            per-requester request level
//  req_data     in   NUM_REQ*BUS_WIDTH  packed words, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//  grant        out  NUM_REQ            one-hot, 1-cycle pulse: word of that requester latched
//  unsync_bus   out  BUS_WIDTH          word to DATA_SYNC, registered
//  bus_enable   out  1                  to DATA_SYNC, registered, high in SEND only
//  ack_sync     in   1                  destination ack level, already synchronized into CLK
//  busy         out  1                  high in any state except IDLE
//  timeout_err  out  1                  1-cycle pulse when SEND aborts on ACK_TIMEOUT
// BEHAVIOUR
//  Reset (RST=0 at edge): state=IDLE, grant=0, unsync_bus=0, bus_enable=0, busy=0,
//   timeout_err=0, rr pointer=NUM_REQ-1 (so requester 0 has top priority first).
//   Reset mid-transfer aborts immediately; no grant re-issued for the lost word.
//  States: IDLE, SEND, RELEASE.
//  IDLE: if |req at edge -> winner w = first set bit searching from ptr+1 upward, wrapping;
//   latch req_data[w] into unsync_bus, grant[w]=1 for that cycle, ptr<=w, bus_enable<=1,
//   hold/timeout counters<=0, state<=SEND. No req -> stay, outputs unchanged.
//   Latency: req sampled at edge k -> grant, unsync_bus, bus_enable valid after edge k.
//  SEND: counter increments each cycle. Leave when counter>=HOLD_CYCLES-1 AND ack_sync=1:
//   bus_enable<=0, state<=RELEASE. If counter reaches ACK_TIMEOUT-1 with no ack:
//   bus_enable<=0, timeout_err pulse, state<=RELEASE. Ack before hold satisfied is ignored
//   until hold done (bus_enable still high exactly HOLD_CYCLES minimum).
//  RELEASE: bus_enable=0, unsync_bus held. ack_sync=0 at edge -> state<=IDLE. New request
//   may be arbitrated only from IDLE, so back-to-back words have >=1 idle cycle.
//  grant is zero in every cycle except the IDLE->SEND edge result; never two bits set.
//  req dropped after grant is not required; a held req re-competes in rr order.
//  req deasserted while not granted: no effect, no memory of past requests.
//  Counters sized $clog2(ACK_TIMEOUT)+1; no wrap possible (bounded by timeout).
//  timeout_err and ack arriving on same edge: ack wins (normal exit, no error).
// STRUCTURE
//  bus_sync_pkg (include file): state encodings IDLE/SEND/RELEASE as localparams,
//   counter-width function, default parameter constants.
//  Sub-module rr_arbiter #(NUM_REQ): combinational; in req, ptr -> one-hot winner + index.
//  Top holds FSM, counters, data latch, ptr register. Expected 150-250 lines total.
// TESTING
//  Clock 40 ns period, DATA_SYNC NUM_STAGES=2 downstream, ack model echoes enable_pulse
//   as a level until bus_enable falls, through a 2-flop synchronizer.
//  T1 reset: RST=0 two edges with req=4'b1111 -> grant=0, bus_enable=0, unsync_bus=0, busy=0.
//  T2 single: req=4'b0100, data[2]=8'h08 -> grant=4'b0100 one cycle, unsync_bus=8'h08,
//   bus_enable high >=3 cycles, destination sync_bus=8'h08, back to IDLE after ack drops.
//  T3 round robin: req=4'b1111 held, data i=8'h10+i -> grant order 0,1,2,3,0; each word
//   arrives once at sync_bus in that order.
//  T4 timeout: ack tied 0, req=4'b0001 -> bus_enable falls after 16 cycles, timeout_err
//   pulses once, then state IDLE and next grant proceeds.
//  T5 early ack: ack_sync=1 one cycle after bus_enable rises -> bus_enable still high
//   exactly 3 cycles, then RELEASE until ack_sync=0.
//  T6 reset mid-SEND: RST=0 at cycle 2 of SEND -> bus_enable=0 next edge, ptr=3, grant=0.

Source files
------------

// File: rtl/bus_sync_tx_arbiter_pkg.sv
// Shared types and constants for the DATA_SYNC transmit-side arbiter.
// The FSM state encoding and the counter-width helper live here.
package bus_sync_tx_arbiter_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_BUS_WIDTH   = 8;
  localparam int DEF_HOLD_CYCLES = 3;
  localparam int DEF_ACK_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // One spare bit above the timeout range so the compare never sees a wrap.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/bus_sync_tx_arbiter_if.sv
// Requester/crossing bundle between the requesters, the arbiter and the DATA_SYNC link.
// slave = arbiter side, master = requester/crossing side.
interface bus_sync_tx_arbiter_if
  import bus_sync_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int BUS_WIDTH = DEF_BUS_WIDTH
);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           grant;
  logic [BUS_WIDTH-1:0]         unsync_bus;
  logic                         bus_enable;
  logic                         ack_sync;
  logic                         busy;
  logic                         timeout_err;

  modport slave (
    input  req, req_data, ack_sync,
    output grant, unsync_bus, bus_enable, busy, timeout_err
  );

  modport master (
    output req, req_data, ack_sync,
    input  grant, unsync_bus, bus_enable, busy, timeout_err
  );

endinterface

// File: rtl/bus_sync_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
// Produces a one-hot winner, its index and a valid flag.
module rr_arbiter
  import bus_sync_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDXW-1:0]    index,
  output logic               valid
);

  logic [IDXW-1:0] cand;

  // Walk from the farthest candidate back to ptr+1 so the nearest one overrides.
  always_comb begin
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDXW'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
        index        = cand;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_sync_tx_arbiter.sv
// Source-side controller sharing one DATA_SYNC crossing among NUM_REQ requesters:
// round-robin pick, registered word/enable, four-phase handshake with hold and timeout.
module bus_sync_tx_arbiter
  import bus_sync_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst,
  bus_sync_tx_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = cnt_width(ACK_TIMEOUT);
  localparam logic [CNTW-1:0] HOLD_LAST    = CNTW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] TIMEOUT_LAST = CNTW'(ACK_TIMEOUT - 1);
  localparam logic [IDXW-1:0] PTR_RESET    = IDXW'(NUM_REQ - 1);

  state_t               state_reg, state_next;
  logic [IDXW-1:0]      ptr_reg, ptr_next;
  logic [CNTW-1:0]      cnt_reg, cnt_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [BUS_WIDTH-1:0] data_reg, data_next;
  logic                 enable_reg, enable_next;
  logic                 timeout_reg, timeout_next;

  logic [BUS_WIDTH-1:0] words [NUM_REQ];
  logic [NUM_REQ-1:0]   win_onehot;
  logic [IDXW-1:0]      win_index;
  logic                 win_valid;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = bus.req_data[gi*BUS_WIDTH +: BUS_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (bus.req),
    .ptr    (ptr_reg),
    .winner (win_onehot),
    .index  (win_index),
    .valid  (win_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= PTR_RESET;
      cnt_reg     <= '0;
      grant_reg   <= '0;
      data_reg    <= '0;
      enable_reg  <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      grant_reg   <= grant_next;
      data_reg    <= data_next;
      enable_reg  <= enable_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    grant_next   = '0;
    data_next    = data_reg;
    enable_next  = enable_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_valid) begin
          grant_next  = win_onehot;
          data_next   = words[win_index];
          ptr_next    = win_index;
          enable_next = 1'b1;
          cnt_next    = '0;
          state_next  = ST_SEND;
        end
      end
      ST_SEND: begin
        // Ack is only honoured once the hold time is met; it beats a simultaneous timeout.
        if (cnt_reg >= HOLD_LAST && bus.ack_sync) begin
          enable_next = 1'b0;
          state_next  = ST_RELEASE;
        end else if (cnt_reg >= TIMEOUT_LAST) begin
          enable_next  = 1'b0;
          timeout_next = 1'b1;
          state_next   = ST_RELEASE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!bus.ack_sync) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        enable_next = 1'b0;
      end
    endcase
  end

  assign bus.grant       = grant_reg;
  assign bus.unsync_bus  = data_reg;
  assign bus.bus_enable  = enable_reg;
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.timeout_err = timeout_reg;

endmodule

// File: tb/tb_bus_sync_tx_arbiter.sv
// Randomized bench for bus_sync_tx_arbiter with a DATA_SYNC-style destination and ack echo.
// Expected winners and words come from a round-robin reference model over request vectors.
module tb_bus_sync_tx_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 3;
  localparam int TMO  = 16;

  logic clk  = 1'b0;
  logic dclk = 1'b0;
  logic rst  = 1'b0;

  always #20 clk = ~clk;
  always #15 dclk = ~dclk;

  bus_sync_tx_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(W)) bus ();

  bus_sync_tx_arbiter #(
    .NUM_REQ(N), .BUS_WIDTH(W), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int m_ptr    = N - 1;
  int txn      = 0;

  // ack source: 0 = destination echo model, 1 = tied low, 2 = forced by the bench
  int   ack_mode  = 0;
  logic ack_force = 1'b0;

  logic en_s1, en_s2, en_s3, ack_lvl, ack_s1, ack_s2;
  logic [W-1:0] sync_bus;
  logic [W-1:0] recv_q [$];

  assign bus.ack_sync = (ack_mode == 0) ? ack_s2 : (ack_mode == 1) ? 1'b0 : ack_force;

  // Destination: 2-stage enable synchronizer, edge pulse captures the word, ack echoes as a level
  always @(posedge dclk) begin
    if (!rst) begin
      en_s1    <= 1'b0;
      en_s2    <= 1'b0;
      en_s3    <= 1'b0;
      ack_lvl  <= 1'b0;
      sync_bus <= '0;
    end else begin
      en_s1 <= bus.bus_enable;
      en_s2 <= en_s1;
      en_s3 <= en_s2;
      if (en_s2 && !en_s3) begin
        sync_bus <= bus.unsync_bus;
        recv_q.push_back(bus.unsync_bus);
        ack_lvl  <= 1'b1;
      end else if (!en_s2) begin
        ack_lvl <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= ack_lvl;
      ack_s2 <= ack_s1;
    end
  end

  // Cycle-level invariants: at most one grant bit, never two grant cycles in a row,
  // enable implies busy, word stable while enable stays high.
  logic         prev_en    = 1'b0;
  logic [N-1:0] prev_grant = '0;
  logic [W-1:0] prev_bus   = '0;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ($countones(bus.grant) > 1) begin
        failures++;
        $display("FAIL grant_onehot: grant=%b required at most one bit", bus.grant);
      end
      checks++;
      if (prev_grant != '0 && bus.grant != '0) begin
        failures++;
        $display("FAIL grant_pulse: grant=%b prev=%b required a single-cycle pulse", bus.grant, prev_grant);
      end
      checks++;
      if (bus.bus_enable && !bus.busy) begin
        failures++;
        $display("FAIL busy_with_enable: busy=%b required 1 while bus_enable=1", bus.busy);
      end
      if (prev_en && bus.bus_enable) begin
        checks++;
        if (bus.unsync_bus !== prev_bus) begin
          failures++;
          $display("FAIL bus_stable: unsync_bus=%h required %h", bus.unsync_bus, prev_bus);
        end
      end
    end
    prev_en    <= rst ? bus.bus_enable : 1'b0;
    prev_grant <= rst ? bus.grant : '0;
    prev_bus   <= bus.unsync_bus;
  end

  typedef struct {
    bit           got;
    logic [N-1:0] grant;
    logic [W-1:0] data;
    logic         en;
    int           high;
    int           errs;
    bit           stable;
    bit           idle;
    int           rx_n;
    logic [W-1:0] rx;
  } obs_t;

  // Reference arbitration: first requester after the last winner, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (p + k) % N;
      if (r[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    bus.req_data[i*W +: W] = v;
  endtask

  task automatic do_reset;
    rst     = 1'b0;
    bus.req = '0;
    tick;
    tick;
    rst   = 1'b1;
    m_ptr = N - 1;
    recv_q.delete();
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_enable_low(output int high, output int errs, output bit stable);
    logic [W-1:0] held;
    held   = bus.unsync_bus;
    high   = 0;
    errs   = 0;
    stable = 1'b1;
    do begin
      high++;
      if (bus.unsync_bus !== held) stable = 1'b0;
      tick;
      if (bus.timeout_err) errs++;
    end while (bus.bus_enable === 1'b1 && high < 100);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  // Observe one full transfer; req is replaced by req_after once the grant is seen.
  task automatic run_txn(input logic [N-1:0] req_after, output obs_t o);
    o = '{default: '0};
    wait_grant(o.got);
    if (!o.got) return;
    o.grant = bus.grant;
    o.data  = bus.unsync_bus;
    o.en    = bus.bus_enable;
    bus.req = req_after;
    wait_enable_low(o.high, o.errs, o.stable);
    wait_idle(o.idle);
    o.rx_n = recv_q.size();
    o.rx   = (o.rx_n > 0) ? recv_q.pop_front() : 'x;
    txn++;
    $display("txn %0d: grant=%b word=%h enable_cycles=%0d timeouts=%0d received=%h",
             txn, o.grant, o.data, o.high, o.errs, o.rx);
  endtask

  task automatic test_reset;
    rst     = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) set_word(i, W'($urandom));
    tick;
    tick;
    checks++;
    if (bus.grant !== '0) begin failures++; $display("FAIL reset_grant: got %b required 0", bus.grant); end
    checks++;
    if (bus.bus_enable !== 1'b0) begin failures++; $display("FAIL reset_enable: got %b required 0", bus.bus_enable); end
    checks++;
    if (bus.unsync_bus !== '0) begin failures++; $display("FAIL reset_bus: got %h required 0", bus.unsync_bus); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++;
    if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b required 0", bus.timeout_err); end
    bus.req = '0;
    rst     = 1'b1;
    m_ptr   = N - 1;
    recv_q.delete();
    tick;
  endtask

  task automatic test_single;
    obs_t o;
    for (int i = 0; i < N; i++) set_word(i, W'($urandom));
    set_word(2, 8'h08);
    bus.req = 4'b0100;
    run_txn('0, o);
    checks++;
    if (!o.got || o.grant !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b required 0100", o.grant); end
    checks++;
    if (o.data !== 8'h08 || o.en !== 1'b1) begin failures++; $display("FAIL single_word: got %h en=%b required 08 en=1", o.data, o.en); end
    checks++;
    if (o.high < HOLD || o.errs != 0) begin failures++; $display("FAIL single_hold: got %0d cycles %0d timeouts required >=%0d and 0", o.high, o.errs, HOLD); end
    checks++;
    if (!o.idle || o.rx_n != 1 || o.rx !== 8'h08 || sync_bus !== 8'h08) begin
      failures++;
      $display("FAIL single_dest: idle=%b count=%0d word=%h sync_bus=%h required 1/1/08/08", o.idle, o.rx_n, o.rx, sync_bus);
    end
    m_ptr = 2;
  endtask

  task automatic test_round_robin;
    obs_t o;
    int w;
    do_reset;
    for (int i = 0; i < N; i++) set_word(i, W'(8'h10 + i));
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      w = rr_pick(4'b1111, m_ptr);
      run_txn((t == 4) ? 4'b0000 : 4'b1111, o);
      checks++;
      if (!o.got || o.grant !== N'(1 << w)) begin failures++; $display("FAIL rr_grant[%0d]: got %b required %b", t, o.grant, N'(1 << w)); end
      checks++;
      if (o.data !== W'(8'h10 + w) || o.rx_n != 1 || o.rx !== W'(8'h10 + w)) begin
        failures++;
        $display("FAIL rr_word[%0d]: latched %h received %h count %0d required %h once", t, o.data, o.rx, o.rx_n, W'(8'h10 + w));
      end
      checks++;
      if (!o.idle || o.errs != 0) begin failures++; $display("FAIL rr_release[%0d]: idle=%b timeouts=%0d required 1 and 0", t, o.idle, o.errs); end
      m_ptr = w;
    end
  endtask

  task automatic test_random;
    obs_t o;
    logic [N-1:0] r;
    logic [W-1:0] words [N];
    int w;
    for (int t = 0; t < 12; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        words[i] = W'($urandom);
        set_word(i, words[i]);
      end
      w = rr_pick(r, m_ptr);
      bus.req = r;
      run_txn('0, o);
      checks++;
      if (!o.got || o.grant !== N'(1 << w)) begin failures++; $display("FAIL rand_grant[%0d]: req=%b got %b required %b", t, r, o.grant, N'(1 << w)); end
      checks++;
      if (o.data !== words[w] || o.rx !== words[w] || o.rx_n != 1) begin
        failures++;
        $display("FAIL rand_word[%0d]: latched %h received %h count %0d required %h once", t, o.data, o.rx, o.rx_n, words[w]);
      end
      checks++;
      if (o.high < HOLD || o.high >= TMO || o.errs != 0 || !o.stable || !o.idle) begin
        failures++;
        $display("FAIL rand_handshake[%0d]: cycles=%0d timeouts=%0d stable=%b idle=%b", t, o.high, o.errs, o.stable, o.idle);
      end
      m_ptr = w;
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    ack_mode = 1;
    bus.req  = 4'b0001;
    for (int pass = 0; pass < 2; pass++) begin
      run_txn((pass == 0) ? 4'b0001 : 4'b0000, o);
      checks++;
      if (!o.got || o.grant !== 4'b0001) begin failures++; $display("FAIL tmo_grant[%0d]: got %b required 0001", pass, o.grant); end
      checks++;
      if (o.high != TMO || o.errs != 1) begin failures++; $display("FAIL tmo_abort[%0d]: cycles=%0d pulses=%0d required %0d and 1", pass, o.high, o.errs, TMO); end
      checks++;
      if (!o.idle) begin failures++; $display("FAIL tmo_idle[%0d]: busy=%b required 0", pass, bus.busy); end
    end
    m_ptr = 0;
    repeat (10) tick;
    ack_mode = 0;
    recv_q.delete();
  endtask

  task automatic test_early_ack;
    bit ok;
    int high, errs, w;
    bit stable;
    ack_mode  = 2;
    ack_force = 1'b0;
    w = rr_pick(4'b0010, m_ptr);
    bus.req = 4'b0010;
    wait_grant(ok);
    checks++;
    if (!ok || bus.grant !== N'(1 << w)) begin failures++; $display("FAIL early_grant: got %b required %b", bus.grant, N'(1 << w)); end
    m_ptr     = w;
    bus.req   = '0;
    ack_force = 1'b1;
    wait_enable_low(high, errs, stable);
    checks++;
    if (high != HOLD || errs != 0) begin failures++; $display("FAIL early_hold: cycles=%0d pulses=%0d required %0d and 0", high, errs, HOLD); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.bus_enable !== 1'b0) begin
        failures++;
        $display("FAIL early_release[%0d]: busy=%b enable=%b required 1 and 0", i, bus.busy, bus.bus_enable);
      end
      tick;
    end
    ack_force = 1'b0;
    tick;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL early_idle: busy=%b required 0", bus.busy); end

    // Ack on the very edge the timeout would fire: normal exit, no error pulse
    w = rr_pick(4'b1000, m_ptr);
    bus.req = 4'b1000;
    wait_grant(ok);
    checks++;
    if (!ok || bus.grant !== N'(1 << w)) begin failures++; $display("FAIL race_grant: got %b required %b", bus.grant, N'(1 << w)); end
    m_ptr   = w;
    bus.req = '0;
    repeat (TMO - 1) tick;
    checks++;
    if (bus.bus_enable !== 1'b1) begin failures++; $display("FAIL race_enable_before: got %b required 1", bus.bus_enable); end
    ack_force = 1'b1;
    tick;
    checks++;
    if (bus.bus_enable !== 1'b0 || bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL race_ack_wins: enable=%b timeout_err=%b busy=%b required 0/0/1", bus.bus_enable, bus.timeout_err, bus.busy);
    end
    ack_force = 1'b0;
    tick;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL race_idle: busy=%b required 0", bus.busy); end
    repeat (10) tick;
    ack_mode = 0;
    recv_q.delete();
  endtask

  task automatic test_reset_mid_send;
    bit ok;
    int high, errs, w;
    bit stable;
    bus.req = 4'b0100;
    wait_grant(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_grant: got %b required a grant", bus.grant); end
    bus.req = '0;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (bus.bus_enable !== 1'b0 || bus.grant !== '0 || bus.busy !== 1'b0 || bus.unsync_bus !== '0) begin
      failures++;
      $display("FAIL midrst_abort: enable=%b grant=%b busy=%b bus=%h required all 0",
               bus.bus_enable, bus.grant, bus.busy, bus.unsync_bus);
    end
    rst   = 1'b1;
    m_ptr = N - 1;
    w = rr_pick(4'b1111, m_ptr);
    bus.req = 4'b1111;
    wait_grant(ok);
    checks++;
    if (!ok || bus.grant !== N'(1 << w)) begin failures++; $display("FAIL midrst_ptr: got %b required %b", bus.grant, N'(1 << w)); end
    bus.req = '0;
    wait_enable_low(high, errs, stable);
    wait_idle(ok);
    checks++;
    if (!ok || errs != 0) begin failures++; $display("FAIL midrst_finish: idle=%b pulses=%0d required 1 and 0", ok, errs); end
    repeat (5) tick;
    recv_q.delete();
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_random;
    test_timeout;
    test_early_ack;
    test_reset_mid_send;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
